// File: rtl/rr_hold_arb_pkg.sv
// Shared types and parameter limits for the round-robin hold-until-release arbiter.
// Imported by rr_pick and rr_hold_arbiter.
package rr_hold_arb_pkg;

  localparam int MAX_NUM_REQ    = 16;
  localparam int MAX_HOLD_LIMIT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// rr_pick: combinational round-robin selector, first set req at or above ptr with wrap.
// Double-width masked priority select; winner index is folded back modulo NUM_REQ.
module rr_pick
  import rr_hold_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] masked;
  logic                 found;

  always_comb begin
    dbl    = {req_i, req_i};
    masked = '0;
    // Lower copy only keeps bits at or above ptr; upper copy supplies the wrap-around.
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr_i));
    end

    any_o = |req_i;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx_o = IW'(i % NUM_REQ);
      end
    end

    onehot_o = '0;
    if (any_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin hold-until-release arbiter with a one-cycle dead gap after every grant.
// Optional watchdog revocation built when RR_HOLD_ARB_TIMEOUT_EN is defined.
module rr_hold_arbiter
  import rr_hold_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int IW       = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_id_o,
  output logic               busy_o,
  output logic               timeout_o
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ ||
      MAX_HOLD < 2 || MAX_HOLD > MAX_HOLD_LIMIT) begin : g_bad_params
    $error("rr_hold_arbiter: NUM_REQ or MAX_HOLD out of range");
  end

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               wd_fire;
  logic [IW-1:0]      ptr_next;

`ifdef RR_HOLD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Counter holds (GRANT cycles so far - 1); fires on the MAX_HOLD-th cycle.
  assign wd_fire   = (cnt_q == CW'(MAX_HOLD - 1));
  assign timeout_o = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign owner_req = req_i[gnt_id_q];
  assign ptr_next  = (gnt_id_q == IW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE, GAP: begin
        if (pick_any) begin
          state_d  = GRANT;
          gnt_d    = pick_onehot;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end

      GRANT: begin
`ifdef RR_HOLD_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (!owner_req || wd_fire) begin
          state_d = GAP;
          ptr_d   = ptr_next;
          gnt_d   = '0;
          busy_d  = 1'b0;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
          // A release in the expiry cycle wins: no timeout pulse.
          timeout_d = owner_req;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = gnt_id_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter with NUM_REQ=4, MAX_HOLD=8.
// Watchdog expectations follow RR_HOLD_ARB_TIMEOUT_EN.
module tb_rr_hold_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_hold_arbiter #(
    .NUM_REQ  (4),
    .MAX_HOLD (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                            input logic eb, input logic et);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {gnt, gnt_id, busy, timeout};
    exp = {eg, eid, eb, et};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
             tag, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    #1;
    expect_out("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (3) tick();
    expect_out("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Single requester 2, held, then released; ptr should land on 3.
    req = 4'b0100;
    tick();
    expect_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    expect_out("single_release_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    expect_out("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b1001;
    tick();
    expect_out("ptr_is_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("owner3_gap", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    expect_out("owner3_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Fair rotation between requesters 0 and 1.
    req = 4'b0011;
    tick();
    expect_out("rot_g0a", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    expect_out("rot_g0a_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0010;
    tick();
    expect_out("rot_gap1", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("rot_g1a", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    expect_out("rot_g1a_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    expect_out("rot_gap2", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("rot_g0b", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    expect_out("rot_g0b_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0010;
    tick();
    expect_out("rot_gap3", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("rot_g1b", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("rot_gap4", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("rot_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Requester 2 owns; a pulse on req[0] during the grant is lost.
    req = 4'b0100;
    tick();
    expect_out("lost_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0101;
    tick();
    expect_out("lost_ignored", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0100;
    tick();
    expect_out("lost_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("lost_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    // Lone releasing requester re-requests in the gap and gets it back.
    req = 4'b0100;
    tick();
    expect_out("regrant_alone", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("regrant_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    expect_out("regrant_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Async reset mid-grant of requester 3.
    req = 4'b1000;
    tick();
    expect_out("arst_pre_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    expect_out("arst_immediate", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1001;
    #1;
    rst = 1'b0;
    tick();
    expect_out("arst_ptr_zero", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("arst_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // All four requesting continuously.
    req = 4'b1111;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        expect_out("wd_grant", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
      end
      tick();
      expect_out("wd_timeout_gap", 4'b0000, 2'(k), 1'b0, 1'b1);
    end
    tick();
    expect_out("wd_wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      tick();
      expect_out("coll_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`else
    for (int c = 0; c < 30; c++) begin
      tick();
      expect_out("nowd_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif
    req = 4'b1110;
    tick();
    expect_out("coll_release_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("coll_next_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("final_gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("final_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Round-robin, hold-until-release arbiter sharing one resource among NUM_REQ requesters. It is the N-way generalisation of the team's two-requester grant FSM. A requester keeps its grant for as long as it holds its request, with an optional watchdog that forcibly revokes a grant. Every grant is followed by one dead cycle so the resource can change hands cleanly. The block sits between the requesting agents and the shared datapath's select/enable logic.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- MAX_HOLD, 16: maximum consecutive grant cycles per owner, 2..255. Used only with the timeout feature.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  NUM_REQ  level request per requester. Deasserting req while granted means release.
- gnt  out  NUM_REQ  registered one-hot grant, all-zero when nobody owns the resource.
- gnt_id  out  $clog2(NUM_REQ)  registered index of the owner; holds its last value when gnt is 0.
- busy  out  1  registered; equals |gnt.
- timeout  out  1  registered one-cycle pulse when a grant was revoked by the watchdog.

## Operation
- States: IDLE, GRANT, GAP. Reset state is IDLE.
- Reset values: gnt=0, gnt_id=0, busy=0, timeout=0, rotating pointer ptr=0, hold counter=0.
- Selection in IDLE and GAP:
  - Pick the first set req bit at or above ptr, wrapping modulo NUM_REQ.
  - If any req is set, go to GRANT and register gnt, gnt_id and busy for the winner.
  - If no req is set, go to (or stay in) IDLE.
- GRANT:
  - gnt is held stable.
  - Exit to GAP when req[gnt_id]==0 (release) or the watchdog fires.
  - On exit: ptr <= (gnt_id+1) mod NUM_REQ; gnt <= 0; busy <= 0.
  - Requests from other requesters are ignored while in GRANT.
- GAP:
  - Lasts exactly one cycle with gnt=0.
  - Arbitrates with the updated ptr.
  - A releasing requester that immediately re-requests is re-granted only if no other requester is waiting.
- Watchdog (timeout feature only):
  - The counter clears on entry to GRANT and increments on each GRANT cycle.
  - On the MAX_HOLD-th GRANT cycle with req[gnt_id] still 1, the FSM exits to GAP and timeout=1 during the GAP cycle.
- Simultaneous release and watchdog expiry in the same cycle counts as a release: timeout stays 0.
- A request asserted and dropped while another requester owns the grant is lost. No request latching.

## Timing
- Request to grant latency: req sampled in IDLE at edge n gives gnt visible after edge n (one registered stage).
- Release to gnt low: req[owner] low before edge n gives gnt=0 after edge n.
- Handover: the next owner's gnt appears after edge n+1.
- Minimum gap between two different grants: exactly 1 cycle.
- Grant duration with the watchdog: at most MAX_HOLD cycles.
- timeout is high for exactly one cycle, coincident with GAP.
- Reset asserted mid-grant:
  - gnt, busy and timeout go to 0 without waiting for a clock edge.
  - ptr returns to 0.
  - The first grant after reset follows the normal IDLE latency.

## Configuration
- RR_HOLD_ARB_TIMEOUT_EN
  - Defined: the hold counter (width $clog2(MAX_HOLD+1)) and forced revocation are built; the timeout output is driven as above.
  - Undefined: no counter exists; GRANT exits only on release; timeout is tied to 0; MAX_HOLD is ignored.

## Structure
- Package rr_hold_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, GRANT, GAP}.
  - Parameter limits MAX_NUM_REQ=16 and MAX_HOLD_LIMIT=255.
- Sub-module rr_pick, purely combinational:
  - Inputs: req and ptr.
  - Outputs: one-hot winner, winner index, any.
  - Implemented as double-width masked priority select.
  - Instantiated once and shared by IDLE and GAP.
- The top level holds the FSM, the pointer, the output registers and the optional watchdog.

## Test plan
All scenarios use NUM_REQ=4 and MAX_HOLD=8.

- Reset check: hold reset 3 cycles, then req=0 for 10 cycles -> gnt=0, gnt_id=0, busy=0, timeout=0 throughout.
- Single requester: req=4'b0100 at cycle 0 -> gnt=4'b0100 and gnt_id=2 after edge 1. Drop req at cycle 5 -> gnt=0 after edge 6, ptr=3.
- Fair rotation: req=4'b0011; each owner drops its req 2 cycles after being granted, then re-raises it -> grant order 0,1,0,1 with one 0-cycle between grants.
- Watchdog (macro defined): req=4'b1111 constant -> grants 0,1,2,3,0, each 8 cycles long, 1 gap cycle between, timeout=1 in every gap. With the macro undefined: gnt stays 4'b0001 forever and timeout=0.
- Release/timeout collision: owner 0 drops req on its 8th GRANT cycle -> GAP follows with timeout=0, and the next grant goes to the next waiting index above 0.
- Async reset mid-grant: reset pulsed between edges while gnt=4'b1000 -> gnt=0 before the next edge. Then req=4'b1001 -> gnt=4'b0001, because ptr was reset to 0.
